sar_adc_responder: RTL and testbench

SAR_ADC_RESPONDER -- requirements
Module: sar_adc_responder

---
 rtl/sar_adc_responder.sv | 102 ++++++++++
 tb/tb_sar_adc_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_responder.sv
// Sample-and-hold plus comparator emulator that answers a SAR controller and scores each conversion.
//  state   | meaning
//  IDLE    | waiting for a stimulus word on vin
//  GO      | start pulse issued, waiting for the controller to sample
//  TRACK   | controller sampling; held code frozen when sample drops
//  CONVERT | comparator answers trial codes until valid
//  CHECK   | one-cycle result scoring slot
module sar_adc_responder #(
  parameter int N   = 8,
  parameter int TMO = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] vin,
  input  logic         vin_valid,
  output logic         vin_ready,
  output logic         go,
  input  logic         sample,
  input  logic [N-1:0] value,
  input  logic         valid,
  input  logic [N-1:0] result,
  output logic         cmp,
  output logic [N-1:0] held,
  output logic         done,
  output logic         match,
  output logic         timeout,
  output logic [15:0]  conv_count,
  output logic [15:0]  err_count
);
  localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TMO - 1);

  typedef enum logic [2:0] {IDLE, GO, TRACK, CONVERT, CHECK} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  trk;
  logic [WW-1:0] wd;
  logic          active, wd_hit, accept, freeze, finish;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign vin_ready = (state == IDLE);
  assign cmp       = (state == CONVERT) && (held >= value);
  assign active    = (state == GO) || (state == TRACK) || (state == CONVERT);
  // The watchdog abort overrides any sample or valid edge seen in the same cycle.
  assign wd_hit    = active && (wd == WD_LAST);
  assign accept    = (state == IDLE) && vin_valid;
  assign freeze    = (state == TRACK) && !sample && !wd_hit;
  assign finish    = (state == CONVERT) && valid && !wd_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vin_valid) state_nx = GO;
      GO:      if (sample)    state_nx = TRACK;
      TRACK:   if (!sample)   state_nx = CONVERT;
      CONVERT: if (valid)     state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (wd_hit) state_nx = IDLE;
  end

  // done/match/timeout and the counters all update on the same edge, so the
  // counts are already current in the cycle where done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go         <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      match      <= 1'b0;
      held       <= '0;
      trk        <= '0;
      wd         <= '0;
      conv_count <= '0;
      err_count  <= '0;
    end else begin
      go      <= accept;
      done    <= wd_hit || finish;
      timeout <= wd_hit;
      if (accept) trk <= vin;
      if (accept)      wd <= '0;
      else if (active) wd <= wd + 1'b1;
      if (freeze) held <= trk;
      if (wd_hit) begin
        match     <= 1'b0;
        err_count <= sat_inc(err_count);
      end else if (finish) begin
        match      <= (result == held);
        conv_count <= sat_inc(conv_count);
        if (result != held) err_count <= sat_inc(err_count);
      end
    end
  end
endmodule

// File: tb/tb_sar_adc_responder.sv
// Directed bench for sar_adc_responder with a behavioural SAR controller (S=3 sample cycles).
module tb_sar_adc_responder;
  localparam int N   = 8;
  localparam int TMO = 64;
  localparam int S   = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] vin = '0;
  logic         vin_valid = 1'b0;
  logic         vin_ready;
  logic         go;
  logic         sample = 1'b0;
  logic [N-1:0] value = '0;
  logic         valid = 1'b0;
  logic [N-1:0] result = '0;
  logic         cmp;
  logic [N-1:0] held;
  logic         done, match, timeout;
  logic [15:0]  conv_count, err_count;

  int checks = 0;
  int failures = 0;
  int mode = 0;          // 0 controller off, 1 ideal, 2 result forced to code+1
  int ctrl_ones = 0;
  int ctrl_zeros = 0;
  int ctrl_trials = 0;
  bit ctrl_abort = 1'b0;
  logic [N-1:0] code;

  sar_adc_responder #(.N(N), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .vin(vin), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .go(go), .sample(sample), .value(value), .valid(valid), .result(result),
    .cmp(cmp), .held(held), .done(done), .match(match), .timeout(timeout),
    .conv_count(conv_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Ideal controller: sample 1 cycle after go for S cycles, N trial cycles, then valid.
  always begin
    @(posedge clk); #1;
    if (mode != 0 && rst && go === 1'b1) begin
      ctrl_ones = 0; ctrl_zeros = 0; ctrl_trials = 0; ctrl_abort = 1'b0;
      @(posedge clk); #1; sample = 1'b1;
      repeat (S - 1) begin @(posedge clk); #1; end
      @(posedge clk); #1; sample = 1'b0;
      code = '0;
      for (int i = N - 1; i >= 0; i--) begin
        @(posedge clk); #1;
        if (!rst) begin ctrl_abort = 1'b1; break; end
        value = code | (8'd1 << i);
        ctrl_trials++;
        #2;
        if (cmp) begin code = value; ctrl_ones++; end
        else ctrl_zeros++;
      end
      if (!ctrl_abort) begin
        @(posedge clk); #1;
        valid = 1'b1;
        result = (mode == 2) ? code + 8'd1 : code;
        #2;
        if (cmp) ctrl_ones++; else ctrl_zeros++;
        @(posedge clk); #1;
        valid = 1'b0;
      end
      sample = 1'b0;
      value = '0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Handshake one word; returns in the first GO cycle with vin scrambled afterwards.
  task automatic offer(input logic [N-1:0] v);
    vin = v; vin_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (vin_ready) begin @(posedge clk); #1; break; end
      @(posedge clk); #1;
    end
    vin_valid = 1'b0;
    vin = ~v;
  endtask

  task automatic run_conv(input logic [N-1:0] v, output int go_cnt, output int lat, output bit ok);
    ok = 1'b0; lat = -1;
    offer(v);
    go_cnt = (go === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (go === 1'b1) go_cnt++;
      if (done === 1'b1) begin ok = 1'b1; lat = k; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; #2;
    checks++;
    if ({go, done, match, timeout, cmp} !== 5'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 00000", {go, done, match, timeout, cmp});
    end
    checks++;
    if (held !== 8'h00 || conv_count !== 16'h0 || err_count !== 16'h0) begin
      failures++; $display("FAIL reset_regs: held=%h conv=%h err=%h want all 0", held, conv_count, err_count);
    end
    checks++;
    if (vin_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b want 1", vin_ready);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (go !== 1'b0) begin failures++; $display("FAIL reset_go_idle: got %b want 0", go); end
  endtask

  task automatic test_basic();
    int gc, lat; bit ok;
    do_reset(); mode = 1;
    run_conv(8'hA5, gc, lat, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done: no done within budget"); end
    checks++;
    if (gc != 1) begin failures++; $display("FAIL basic_go_pulses: got %0d want 1", gc); end
    checks++;
    if (lat != 14) begin failures++; $display("FAIL basic_latency: got %0d want 14", lat); end
    checks++;
    if (held !== 8'hA5) begin failures++; $display("FAIL basic_held: got %h want a5", held); end
    checks++;
    if (match !== 1'b1 || timeout !== 1'b0) begin
      failures++; $display("FAIL basic_match: match=%b timeout=%b want 1 0", match, timeout);
    end
    checks++;
    if (conv_count !== 16'd1 || err_count !== 16'd0) begin
      failures++; $display("FAIL basic_counts: conv=%0d err=%0d want 1 0", conv_count, err_count);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || vin_ready !== 1'b1) begin
      failures++; $display("FAIL basic_done_pulse: done=%b ready=%b want 0 1", done, vin_ready);
    end
  endtask

  task automatic test_back_to_back();
    int gc, lat; bit ok;
    do_reset(); mode = 1;
    run_conv(8'h00, gc, lat, ok);
    checks++;
    if (!ok || match !== 1'b1) begin failures++; $display("FAIL b2b_00_match: ok=%b match=%b want 1 1", ok, match); end
    checks++;
    if (ctrl_ones != 0 || ctrl_zeros != 9) begin
      failures++; $display("FAIL b2b_00_cmp: ones=%0d zeros=%0d want 0 9", ctrl_ones, ctrl_zeros);
    end
    checks++;
    if (cmp !== 1'b0) begin failures++; $display("FAIL b2b_cmp_in_check: got %b want 0", cmp); end
    run_conv(8'hFF, gc, lat, ok);
    checks++;
    if (!ok || match !== 1'b1 || held !== 8'hFF) begin
      failures++; $display("FAIL b2b_ff_match: ok=%b match=%b held=%h want 1 1 ff", ok, match, held);
    end
    checks++;
    if (ctrl_ones != 9 || ctrl_zeros != 0) begin
      failures++; $display("FAIL b2b_ff_cmp: ones=%0d zeros=%0d want 9 0", ctrl_ones, ctrl_zeros);
    end
    checks++;
    if (conv_count !== 16'd2 || err_count !== 16'd0) begin
      failures++; $display("FAIL b2b_counts: conv=%0d err=%0d want 2 0", conv_count, err_count);
    end
  endtask

  task automatic test_mismatch();
    int gc, lat; bit ok;
    do_reset(); mode = 2;
    run_conv(8'h3C, gc, lat, ok);
    checks++;
    if (!ok || match !== 1'b0 || result !== 8'h3D) begin
      failures++; $display("FAIL mismatch_match: ok=%b match=%b result=%h want 1 0 3d", ok, match, result);
    end
    checks++;
    if (conv_count !== 16'd1 || err_count !== 16'd1) begin
      failures++; $display("FAIL mismatch_counts: conv=%0d err=%0d want 1 1", conv_count, err_count);
    end
    mode = 1;
  endtask

  task automatic test_timeout();
    int k, gc;
    do_reset(); mode = 0;
    offer(8'h10);
    gc = (go === 1'b1) ? 1 : 0;
    k = -1;
    for (int c = 1; c <= TMO + 10; c++) begin
      @(posedge clk); #1;
      if (go === 1'b1) gc++;
      if (timeout === 1'b1) begin k = c; break; end
    end
    checks++;
    if (k != TMO) begin failures++; $display("FAIL timeout_cycle: got %0d want %0d", k, TMO); end
    checks++;
    if (gc != 1) begin failures++; $display("FAIL timeout_go_pulses: got %0d want 1", gc); end
    checks++;
    if (done !== 1'b1 || match !== 1'b0) begin
      failures++; $display("FAIL timeout_done: done=%b match=%b want 1 0", done, match);
    end
    checks++;
    if (err_count !== 16'd1 || conv_count !== 16'd0) begin
      failures++; $display("FAIL timeout_counts: conv=%0d err=%0d want 0 1", conv_count, err_count);
    end
    @(posedge clk); #1;
    checks++;
    if (vin_ready !== 1'b1 || timeout !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL timeout_after: ready=%b timeout=%b done=%b want 1 0 0", vin_ready, timeout, done);
    end
    mode = 1;
  endtask

  task automatic test_reset_mid();
    int gc, lat; bit ok; bit hit;
    do_reset(); mode = 1;
    run_conv(8'h21, gc, lat, ok);
    offer(8'h77);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ctrl_trials == 4) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL midrst_reach: 4th CONVERT cycle not reached"); end
    checks++;
    if (cmp !== 1'b1 || held !== 8'h77) begin
      failures++; $display("FAIL midrst_before: cmp=%b held=%h want 1 77", cmp, held);
    end
    rst = 1'b0; #1;
    checks++;
    if ({cmp, go, done, match, timeout} !== 5'b0) begin
      failures++; $display("FAIL midrst_flags: got %b want 00000", {cmp, go, done, match, timeout});
    end
    checks++;
    if (held !== 8'h00 || conv_count !== 16'h0 || err_count !== 16'h0) begin
      failures++; $display("FAIL midrst_regs: held=%h conv=%h err=%h want all 0", held, conv_count, err_count);
    end
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (go !== 1'b0 || vin_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_release: go=%b ready=%b want 0 1", go, vin_ready);
    end
    run_conv(8'h5A, gc, lat, ok);
    checks++;
    if (!ok || match !== 1'b1 || held !== 8'h5A || conv_count !== 16'd1) begin
      failures++; $display("FAIL midrst_reconv: ok=%b match=%b held=%h conv=%0d want 1 1 5a 1", ok, match, held, conv_count);
    end
  endtask

  task automatic test_saturate();
    int gc, lat; bit ok;
    do_reset(); mode = 1;
    @(negedge clk); force dut.conv_count = 16'hFFFF;
    @(negedge clk); release dut.conv_count;
    @(posedge clk); #1;
    checks++;
    if (conv_count !== 16'hFFFF) begin failures++; $display("FAIL sat_preload: got %h want ffff", conv_count); end
    run_conv(8'h33, gc, lat, ok);
    checks++;
    if (!ok || match !== 1'b1) begin failures++; $display("FAIL sat_match: ok=%b match=%b want 1 1", ok, match); end
    @(posedge clk); #1;
    checks++;
    if (conv_count !== 16'hFFFF || err_count !== 16'd0) begin
      failures++; $display("FAIL sat_count: conv=%h err=%h want ffff 0000", conv_count, err_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
